// File: rtl/digota_seq_ctrl.sv
// Output-stage sequencer: synchronizes comparator decisions and enable, filters the decision
// code, and inserts dead-time between drivers. Optional DIGOTA_SEQ_CNT_EN adds the sw_cnt output.
module digota_seq_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 2,
    parameter int unsigned DT_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INmb,
    input  logic        INpb,
    input  logic        oe,
    output logic        opmos,
    output logic        onmos,
    output logic        cmpmos,
    output logic        cmnmos,
`ifdef DIGOTA_SEQ_CNT_EN
    output logic [15:0] sw_cnt,
`endif
    output logic        active
);

    localparam int unsigned FW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    // {opmos, onmos, cmpmos, cmnmos}
    localparam logic [3:0] OUT_OFF  = 4'b1010;
    localparam logic [3:0] OUT_PUSH = 4'b0010;
    localparam logic [3:0] OUT_PULL = 4'b1110;
    localparam logic [3:0] OUT_CMP  = 4'b1000;
    localparam logic [3:0] OUT_CMN  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAD  = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync_pb;
    logic [SYNC_STAGES-1:0] r_sync_mb;
    logic [SYNC_STAGES-1:0] r_sync_oe;
    logic [1:0]             r_cand;
    logic [FW-1:0]          r_filt_cnt;
    logic [1:0]             r_acc_code;
    logic [1:0]             r_drv_code;
    logic [DW-1:0]          r_dead;
    logic [3:0]             r_out;
    logic                   r_active;
`ifdef DIGOTA_SEQ_CNT_EN
    logic [CW-1:0]          r_sw_cnt;
`endif

    logic [1:0]    w_scode;
    logic          w_soe;
    logic          w_same;
    logic [FW-1:0] w_cnt_nxt;
    logic          w_acc;
    logic [1:0]    w_acc_code;

    function automatic logic [3:0] drv_out(input logic [1:0] code);
        case (code)
            2'b01:   drv_out = OUT_PUSH;
            2'b10:   drv_out = OUT_PULL;
            2'b11:   drv_out = OUT_CMP;
            default: drv_out = OUT_CMN;
        endcase
    endfunction

    assign w_scode = {r_sync_pb[SYNC_STAGES-1], r_sync_mb[SYNC_STAGES-1]};
    assign w_soe   = r_sync_oe[SYNC_STAGES-1];

    // Run-length filter; acceptance fires once when the run first reaches FILT_CYCLES
    always_comb begin
        w_same    = (w_scode == r_cand);
        w_cnt_nxt = FW'(1);
        if (w_same) begin
            w_cnt_nxt = (r_filt_cnt == FW'(FILT_CYCLES)) ? r_filt_cnt : r_filt_cnt + FW'(1);
        end
        w_acc      = (w_cnt_nxt == FW'(FILT_CYCLES)) &&
                     !(w_same && (r_filt_cnt == FW'(FILT_CYCLES)));
        w_acc_code = w_acc ? w_scode : r_acc_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sync_pb  <= '0;
            r_sync_mb  <= '0;
            r_sync_oe  <= '0;
            r_cand     <= 2'b00;
            r_filt_cnt <= '0;
            r_acc_code <= 2'b00;
            r_drv_code <= 2'b00;
            r_dead     <= '0;
            r_out      <= OUT_OFF;
            r_active   <= 1'b0;
`ifdef DIGOTA_SEQ_CNT_EN
            r_sw_cnt   <= '0;
`endif
        end else begin
            r_sync_pb  <= {r_sync_pb[SYNC_STAGES-2:0], INpb};
            r_sync_mb  <= {r_sync_mb[SYNC_STAGES-2:0], INmb};
            r_sync_oe  <= {r_sync_oe[SYNC_STAGES-2:0], oe};
            r_cand     <= w_scode;
            r_filt_cnt <= w_cnt_nxt;
            if (w_acc) begin
                r_acc_code <= w_scode;
            end

            // Disable wins over everything, with no dead-time
            if (!w_soe) begin
                r_state  <= ST_IDLE;
                r_dead   <= '0;
                r_out    <= OUT_OFF;
                r_active <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state  <= ST_DEAD;
                        r_dead   <= DW'(DT_CYCLES);
                        r_out    <= OUT_OFF;
                        r_active <= 1'b0;
                    end
                    ST_DEAD: begin
                        if (r_dead <= DW'(1)) begin
                            r_state    <= ST_DRIVE;
                            r_dead     <= '0;
                            r_drv_code <= w_acc_code;
                            r_out      <= drv_out(w_acc_code);
                            r_active   <= 1'b1;
`ifdef DIGOTA_SEQ_CNT_EN
                            if (r_sw_cnt != {CW{1'b1}}) begin
                                r_sw_cnt <= r_sw_cnt + CW'(1);
                            end
`endif
                        end else begin
                            r_dead <= r_dead - DW'(1);
                        end
                    end
                    ST_DRIVE: begin
                        if (w_acc && (w_scode != r_drv_code)) begin
                            r_state  <= ST_DEAD;
                            r_dead   <= DW'(DT_CYCLES);
                            r_out    <= OUT_OFF;
                            r_active <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_dead   <= '0;
                        r_out    <= OUT_OFF;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign opmos  = r_out[3];
    assign onmos  = r_out[2];
    assign cmpmos = r_out[1];
    assign cmnmos = r_out[0];
    assign active = r_active;
`ifdef DIGOTA_SEQ_CNT_EN
    assign sw_cnt = r_sw_cnt;
`endif

endmodule

// File: doc/digota_seq_ctrl.md
DIGOTA_SEQ_CTRL -- requirements
Module: digota_seq_ctrl

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for INmb, INpb and oe (legal 2..4).
REQ-002 The module SHALL have parameter FILT_CYCLES, default 2, giving the consecutive synchronized cycles a decision code must hold to be accepted (legal 1..15).
REQ-003 The module SHALL have parameter DT_CYCLES, default 4, giving the dead-time in clock cycles (legal 1..255).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port INmb, input, 1 bit: async comparator minus-side decision.
REQ-007 The module SHALL have port INpb, input, 1 bit: async comparator plus-side decision.
REQ-008 The module SHALL have port oe, input, 1 bit: async output enable.
REQ-009 The module SHALL have port opmos, output, 1 bit: output PMOS gate, active-low.
REQ-010 The module SHALL have port onmos, output, 1 bit: output NMOS gate, active-high.
REQ-011 The module SHALL have port cmpmos, output, 1 bit: common-mode PMOS gate, active-low.
REQ-012 The module SHALL have port cmnmos, output, 1 bit: common-mode NMOS gate, active-high.
REQ-013 The module SHALL have port active, output, 1 bit: high while in DRIVE.

Function
REQ-014 Decision code {INpb,INmb} SHALL map as: 01 -> PUSH (opmos=0), 10 -> PULL (onmos=1), 11 -> CMP (cmpmos=0), 00 -> CMN (cmnmos=1).
REQ-015 All-off SHALL mean opmos=1, cmpmos=1, onmos=0, cmnmos=0; at most one driver SHALL be on in any cycle.
REQ-016 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-017 Filter: a synchronized code SHALL be accepted when it has been equal on FILT_CYCLES consecutive cycles; any change restarts the count.
REQ-018 FSM states SHALL be IDLE, DEAD and DRIVE.
REQ-019 IDLE: outputs all-off; on synchronized oe=1 -> DEAD, dead counter loaded with DT_CYCLES.
REQ-020 DEAD: outputs all-off; counter decrements each cycle; when it reaches 0 -> DRIVE with the latest accepted code.
REQ-021 An accepted code change during DEAD SHALL update the target code without restarting the dead counter.
REQ-022 DRIVE: the driver for the current code is on; acceptance of a different code SHALL force all-off on the next cycle and enter DEAD (counter = DT_CYCLES).
REQ-023 Re-acceptance of the code currently driven SHALL cause no output change.
REQ-024 A new driver SHALL turn on exactly DT_CYCLES cycles after the first all-off cycle.
REQ-025 Synchronized oe=0 in any state SHALL force all-off on the next cycle and enter IDLE, with no dead-time; this SHALL take priority over a simultaneous code acceptance.
REQ-026 The filter SHALL keep running in IDLE, so a code accepted before oe rises is the DRIVE target.

Reset
REQ-027 rst=1 SHALL, on the next clock edge, set state=IDLE, outputs all-off, active=0, synchronizers and filter to 0, and dead counter to 0.
REQ-028 rst asserted mid-DEAD or mid-DRIVE SHALL produce all-off on the following cycle; after release, normal IDLE behaviour.

Configuration
REQ-029 With macro DIGOTA_SEQ_CNT_EN defined, a 16-bit output sw_cnt SHALL count DEAD->DRIVE transitions, saturate at 0xFFFF, and clear on rst.
REQ-030 Without DIGOTA_SEQ_CNT_EN, port sw_cnt and its counter SHALL be absent and all other behaviour identical.

Verification (defaults SYNC_STAGES=2, FILT_CYCLES=2, DT_CYCLES=4)
REQ-031 Reset: rst=1 for 3 cycles with oe=1, code=01 -> opmos=1, cmpmos=1, onmos=0, cmnmos=0, active=0 throughout.
REQ-032 Enable: code=01 held, oe 0->1 -> 4 all-off cycles after DEAD entry, then opmos=0 and active=1.
REQ-033 Switch: in DRIVE PUSH, code 01->10 held -> opmos=1 next cycle after acceptance, 4 all-off cycles, then onmos=1; no cycle with two drivers on.
REQ-034 Glitch: in DRIVE PULL, code pulses to 11 for 1 cycle -> no output change.
REQ-035 Disable: in DRIVE CMP, oe->0 coincident with code change -> all-off within SYNC_STAGES+1 cycles, state IDLE, no DEAD.
REQ-036 Counter (DIGOTA_SEQ_CNT_EN): 3 code switches -> sw_cnt=4 (including initial enable); forced at 0xFFFF stays 0xFFFF.
